pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline-register and hold/bubble controller that acts on the load-use `stall` request in the R-type/load datapath. It owns the IF/ID register and the ID/EX control slice. It also produces the `id_ex_memread`, `id_ex_rt`, `if_id_rs` and `if_id_rt` fields that the stall detector consumes, which closes the hazard loop. Branch flush and a stall-length watchdog are handled here as well.

## Interface
- `CTRL_W`, 8: width of the ID-stage control bundle.
- `MEMREAD_BIT`, 3: index of MemRead within the control bundle.
- `MAX_STALL`, 3: number of consecutive stall cycles before `stall_err` is raised.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: load-use hazard request from the stall detector.
- `flush` in 1: branch-taken flush from EX.
- `if_instr` in 32: fetched instruction.
- `if_pc_plus4` in 32: PC+4 of the fetched instruction.
- `id_ctrl` in CTRL_W: decoded control for the instruction in ID.
- `pc_write` out 1: PC update enable.
- `if_id_instr` out 32: IF/ID instruction register.
- `if_id_pc_plus4` out 32: IF/ID PC+4 register.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_rs`, `if_id_rt` out 5: `if_id_instr[25:21]` and `if_id_instr[20:16]`.
- `id_ex_ctrl` out CTRL_W: ID/EX control register.
- `id_ex_rt` out 5: ID/EX rt register.
- `id_ex_memread` out 1: `id_ex_ctrl[MEMREAD_BIT]`.
- `id_ex_valid` out 1: ID/EX holds a real instruction.
- `stall_err` out 1: sticky watchdog error.
- `stall_count`, `flush_count` out 16: statistics counters (see Configuration).

## Operation
- Per-cycle action, in priority order: reset > flush > stall > run.
- Run (`stall=0`, `flush=0`):
  - IF/ID loads `if_instr`, `if_pc_plus4`, and sets valid=1.
  - ID/EX loads `id_ctrl` and `if_id_rt`, with `id_ex_valid` <= `if_id_valid`.
- Stall (`stall=1`, `flush=0`):
  - `pc_write`=0.
  - IF/ID holds all fields, including valid.
  - ID/EX takes a bubble: ctrl=0, rt=0, valid=0.
- Flush (`flush=1`, stall ignored):
  - `pc_write`=1.
  - IF/ID loads NOP: instr=0, valid=0, pc_plus4 unchanged.
  - ID/EX takes a bubble.
- `pc_write` = `~stall | flush`. It is combinational and is not registered.
- Two-state FSM for the watchdog, with a consecutive-stall counter (`stall_run`, 3 bits, saturating):
  - RUN -> HOLD when a stall cycle occurs without flush; `stall_run` <= 1.
  - HOLD -> HOLD while the stall persists; `stall_run` increments and saturates at 7.
  - HOLD -> RUN on any non-stall cycle or on flush; `stall_run` <= 0.
  - When `stall_run` reaches `MAX_STALL` in HOLD, `stall_err` <= 1.
  - `stall_err` is cleared only by reset.
- A legal load-use hazard stalls for exactly one cycle. The following cycle sees `id_ex_memread`=0 (bubble), so `stall` drops.

## Timing
- Every register updates on the rising edge of `clk`. Latency from IF to IF/ID is 1 cycle; from IF/ID to ID/EX is 1 cycle.
- Asynchronous reset values, applied immediately on `rst_n`=0:
  - IF/ID: instr=0, pc_plus4=0, valid=0.
  - ID/EX: ctrl=0, rt=0, valid=0.
  - FSM=RUN, `stall_run`=0, `stall_err`=0, counters=0.
- While reset is asserted, `pc_write` follows `~stall | flush`. The PC owner applies its own reset.
- Releasing reset mid-stream resumes in RUN. The first edge loads IF/ID from `if_instr`.
- `stall` and `flush` asserted in the same cycle: the flush result applies, and neither the FSM nor `stall_count` treats it as a stall.
- `stall` asserted while `if_id_valid`=0: the register still holds and the bubble is still inserted. No special case.

## Configuration
- Macro: `PIPE_HAZARD_STATS_EN`.
- Defined:
  - `stall_count` increments on each stall cycle (`stall` & ~`flush`); `flush_count` increments on each flush cycle.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

## Test plan
- Reset: hold `rst_n`=0 mid-stream -> every register is 0, `if_id_valid`=0 and `id_ex_valid`=0 immediately, before the next edge.
- Load-use: issue `lw $t1` (rt=9) followed by `add` with rs=9, driving `stall` as `id_ex_memread` & (`id_ex_rt`==`if_id_rs`/`rt`) -> expected response:
  - `pc_write`=0 for exactly one cycle.
  - IF/ID holds the `add`.
  - `id_ex_ctrl`=0 and `id_ex_valid`=0 for one cycle.
  - The `add` reaches ID/EX on the next cycle.
- Flush: assert `flush`=1 with `if_instr`=0x012A4020 -> expected response:
  - `if_id_instr`=0 and `if_id_valid`=0 next cycle.
  - `id_ex_ctrl`=0.
  - `pc_write`=1.
- Simultaneous events: assert `stall`=1 and `flush`=1 together -> flush behaviour applies; FSM stays in RUN; `stall_count` does not change.
- Watchdog: hold `stall`=1 for 3 cycles with `MAX_STALL`=3 -> `stall_err`=1 after the third edge. It stays 1 after `stall` drops and clears only on `rst_n`=0.
- Statistics (macro defined): drive 5 stall cycles and 2 flush cycles -> `stall_count`=5 and `flush_count`=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - pipeline hazard controller bus bundle
//
// Groups the hazard controller's stage-side signals.
//   master: pipeline/stall detector side (drives stall, flush, IF fields, id_ctrl)
//   slave : pipe_hazard_ctrl (drives pc_write, IF/ID and ID/EX registers,
//           watchdog error and statistics counters)
// CTRL_W is the width of the ID-stage control bundle.

interface pipe_hazard_if #(
    parameter int CTRL_W = 8
);
    logic              stall;
    logic              flush;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc_plus4;
    logic [CTRL_W-1:0] id_ctrl;

    logic              pc_write;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc_plus4;
    logic              if_id_valid;
    logic [4:0]        if_id_rs;
    logic [4:0]        if_id_rt;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [4:0]        id_ex_rt;
    logic              id_ex_memread;
    logic              id_ex_valid;
    logic              stall_err;
    logic [15:0]       stall_count;
    logic [15:0]       flush_count;

    modport master (
        output stall, flush, if_instr, if_pc_plus4, id_ctrl,
        input  pc_write, if_id_instr, if_id_pc_plus4, if_id_valid,
               if_id_rs, if_id_rt, id_ex_ctrl, id_ex_rt, id_ex_memread,
               id_ex_valid, stall_err, stall_count, flush_count
    );

    modport slave (
        input  stall, flush, if_instr, if_pc_plus4, id_ctrl,
        output pc_write, if_id_instr, if_id_pc_plus4, if_id_valid,
               if_id_rs, if_id_rt, id_ex_ctrl, id_ex_rt, id_ex_memread,
               id_ex_valid, stall_err, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID and ID/EX hold/bubble/flush controller with stall watchdog
//
// Owns the IF/ID register and the ID/EX control slice. Per cycle the action
// is reset > flush > stall > run. A stall holds IF/ID and injects a bubble
// into ID/EX; a flush loads a NOP into IF/ID and a bubble into ID/EX.
// A two-state watchdog raises sticky stall_err after MAX_STALL consecutive
// stall cycles.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_if.slave (stall/flush/IF inputs, pipeline register outputs)
//
// Optional feature: define PIPE_HAZARD_STATS_EN to enable the 16-bit
// saturating stall_count/flush_count counters; otherwise both read 0.

module pipe_hazard_ctrl #(
    parameter int CTRL_W      = 8,
    parameter int MEMREAD_BIT = 3,
    parameter int MAX_STALL   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_if.slave       bus
);

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        stall_run;
    logic [2:0]        stall_run_nxt;
    logic              err_set;
    logic              stall_err;
    logic              stall_hold;

    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc_plus4;
    logic              if_id_valid;
    logic [CTRL_W-1:0] id_ex_ctrl;
    logic [4:0]        id_ex_rt;
    logic              id_ex_valid;

    // Flush dominates, so a stall coincident with flush is not a stall at all.
    assign stall_hold = bus.stall & ~bus.flush;

    // Watchdog state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_run <= 3'd0;
            stall_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_run <= stall_run_nxt;
            if (err_set) begin
                stall_err <= 1'b1;
            end
        end
    end

    // Watchdog next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (stall_hold)  state_nxt = ST_HOLD;
            ST_HOLD: if (!stall_hold) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Watchdog outputs. The error is flagged on the edge where the run
    // length reaches MAX_STALL, so it is visible right after that edge.
    always_comb begin
        stall_run_nxt = 3'd0;
        if (stall_hold) begin
            if (state == ST_HOLD) begin
                stall_run_nxt = (stall_run == 3'd7) ? 3'd7 : stall_run + 3'd1;
            end else begin
                stall_run_nxt = 3'd1;
            end
        end
        err_set = stall_hold && ({29'd0, stall_run_nxt} >= 32'(MAX_STALL));
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr    <= 32'd0;
            if_id_pc_plus4 <= 32'd0;
            if_id_valid    <= 1'b0;
            id_ex_ctrl     <= '0;
            id_ex_rt       <= 5'd0;
            id_ex_valid    <= 1'b0;
        end else if (bus.flush) begin
            // pc_plus4 is left as-is; only instr/valid form the NOP.
            if_id_instr    <= 32'd0;
            if_id_valid    <= 1'b0;
            id_ex_ctrl     <= '0;
            id_ex_rt       <= 5'd0;
            id_ex_valid    <= 1'b0;
        end else if (bus.stall) begin
            id_ex_ctrl     <= '0;
            id_ex_rt       <= 5'd0;
            id_ex_valid    <= 1'b0;
        end else begin
            if_id_instr    <= bus.if_instr;
            if_id_pc_plus4 <= bus.if_pc_plus4;
            if_id_valid    <= 1'b1;
            id_ex_ctrl     <= bus.id_ctrl;
            id_ex_rt       <= if_id_instr[20:16];
            id_ex_valid    <= if_id_valid;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (stall_hold && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (bus.flush && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end

    assign bus.stall_count = stall_count;
    assign bus.flush_count = flush_count;
`else
    assign bus.stall_count = 16'd0;
    assign bus.flush_count = 16'd0;
`endif

    // Not registered: the PC owner must see the hold in the same cycle.
    assign bus.pc_write       = ~bus.stall | bus.flush;
    assign bus.if_id_instr    = if_id_instr;
    assign bus.if_id_pc_plus4 = if_id_pc_plus4;
    assign bus.if_id_valid    = if_id_valid;
    assign bus.if_id_rs       = if_id_instr[25:21];
    assign bus.if_id_rt       = if_id_instr[20:16];
    assign bus.id_ex_ctrl     = id_ex_ctrl;
    assign bus.id_ex_rt       = id_ex_rt;
    assign bus.id_ex_memread  = id_ex_ctrl[MEMREAD_BIT];
    assign bus.id_ex_valid    = id_ex_valid;
    assign bus.stall_err      = stall_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] LW_T1  = 32'h8D09_0000; // lw  $t1,0($t0): rs=8 rt=9
    localparam logic [31:0] ADD_I  = 32'h012B_5020; // add $t2,$t1,$t3: rs=9 rt=11
    localparam logic [31:0] NEXT_I = 32'h016C_6820; // add $t5,$t3,$t4: rs=11 rt=12
    localparam logic [7:0]  LW_CTL  = 8'h2B;        // MemRead (bit 3) set
    localparam logic [7:0]  ADD_CTL = 8'h81;

`ifdef PIPE_HAZARD_STATS_EN
    localparam logic [31:0] EXP_STALLS = 32'd5;
    localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    always #5 clk = ~clk;

    pipe_hazard_if #(.CTRL_W(8)) bus ();

    pipe_hazard_ctrl #(
        .CTRL_W(8),
        .MEMREAD_BIT(3),
        .MAX_STALL(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic [31:0] ins,
                         input logic [31:0] pc4, input logic [7:0] ctl);
        bus.stall       = s;
        bus.flush       = f;
        bus.if_instr    = ins;
        bus.if_pc_plus4 = pc4;
        bus.id_ctrl     = ctl;
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h100, 8'hFF);
        #2;
        chk("rst_ifid_instr", bus.if_id_instr, 32'd0);
        chk("rst_ifid_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_idex_ctrl",  {24'd0, bus.id_ex_ctrl}, 32'd0);
        chk("rst_idex_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("rst_stall_err",  {31'd0, bus.stall_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use sequence: lw then dependent add
        drive(1'b0, 1'b0, LW_T1, 32'h104, 8'h00);
        tick();
        chk("lw_ifid", bus.if_id_instr, LW_T1);
        chk("lw_ifid_valid", {31'd0, bus.if_id_valid}, 32'd1);

        drive(1'b0, 1'b0, ADD_I, 32'h108, LW_CTL);
        tick();
        chk("add_ifid", bus.if_id_instr, ADD_I);
        chk("lw_idex_ctrl", {24'd0, bus.id_ex_ctrl}, {24'd0, LW_CTL});
        chk("lw_idex_rt", {27'd0, bus.id_ex_rt}, 32'd9);
        chk("lw_memread", {31'd0, bus.id_ex_memread}, 32'd1);
        chk("add_rs", {27'd0, bus.if_id_rs}, 32'd9);

        drive(bus.id_ex_memread && (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt),
              1'b0, NEXT_I, 32'h10C, ADD_CTL);
        chk("lu_stall_req", {31'd0, bus.stall}, 32'd1);
        chk("lu_pc_write0", {31'd0, bus.pc_write}, 32'd0);
        tick();
        chk("lu_hold_ifid", bus.if_id_instr, ADD_I);
        chk("lu_hold_pc4", bus.if_id_pc_plus4, 32'h108);
        chk("lu_bubble_ctrl", {24'd0, bus.id_ex_ctrl}, 32'd0);
        chk("lu_bubble_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("lu_bubble_memrd", {31'd0, bus.id_ex_memread}, 32'd0);

        drive(bus.id_ex_memread && (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt),
              1'b0, NEXT_I, 32'h10C, ADD_CTL);
        chk("lu_stall_drop", {31'd0, bus.stall}, 32'd0);
        chk("lu_pc_write1", {31'd0, bus.pc_write}, 32'd1);
        tick();
        chk("add_idex_ctrl", {24'd0, bus.id_ex_ctrl}, {24'd0, ADD_CTL});
        chk("add_idex_rt", {27'd0, bus.id_ex_rt}, 32'd11);
        chk("add_idex_valid", {31'd0, bus.id_ex_valid}, 32'd1);
        chk("next_ifid", bus.if_id_instr, NEXT_I);
        chk("lu_no_err", {31'd0, bus.stall_err}, 32'd0);

        // Flush
        drive(1'b0, 1'b1, 32'h012A_4020, 32'h200, 8'h55);
        chk("fl_pc_write", {31'd0, bus.pc_write}, 32'd1);
        tick();
        chk("fl_ifid_instr", bus.if_id_instr, 32'd0);
        chk("fl_ifid_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("fl_ifid_pc4", bus.if_id_pc_plus4, 32'h10C);
        chk("fl_idex_ctrl", {24'd0, bus.id_ex_ctrl}, 32'd0);
        chk("fl_idex_valid", {31'd0, bus.id_ex_valid}, 32'd0);

        // Simultaneous stall and flush: flush wins
        drive(1'b1, 1'b1, 32'h2222_2222, 32'h204, 8'h55);
        chk("sf_pc_write", {31'd0, bus.pc_write}, 32'd1);
        tick();
        chk("sf_ifid_instr", bus.if_id_instr, 32'd0);
        chk("sf_idex_ctrl", {24'd0, bus.id_ex_ctrl}, 32'd0);
        chk("sf_no_err", {31'd0, bus.stall_err}, 32'd0);

        // Run cycle after flush: valid propagates 0 into ID/EX
        drive(1'b0, 1'b0, 32'h1111_1111, 32'h300, 8'h10);
        tick();
        chk("run_ifid", bus.if_id_instr, 32'h1111_1111);
        chk("run_idex_ctrl", {24'd0, bus.id_ex_ctrl}, 32'h10);
        chk("run_idex_valid", {31'd0, bus.id_ex_valid}, 32'd0);

        // Watchdog: three consecutive stalls
        drive(1'b1, 1'b0, 32'h3333_3333, 32'h304, 8'h10);
        tick();
        chk("wd_err_e1", {31'd0, bus.stall_err}, 32'd0);
        chk("wd_hold_ifid", bus.if_id_instr, 32'h1111_1111);
        chk("wd_bubble", {24'd0, bus.id_ex_ctrl}, 32'd0);
        tick();
        chk("wd_err_e2", {31'd0, bus.stall_err}, 32'd0);
        tick();
        chk("wd_err_e3", {31'd0, bus.stall_err}, 32'd1);
        tick();
        chk("wd_ifid_valid", {31'd0, bus.if_id_valid}, 32'd1);
        drive(1'b0, 1'b0, 32'h3333_3333, 32'h304, 8'h10);
        tick();
        chk("wd_err_sticky", {31'd0, bus.stall_err}, 32'd1);
        chk("wd_resume", bus.if_id_instr, 32'h3333_3333);
        chk("st_stall_count", {16'd0, bus.stall_count}, EXP_STALLS);
        chk("st_flush_count", {16'd0, bus.flush_count}, EXP_FLUSHES);

        // Mid-stream asynchronous reset
        drive(1'b1, 1'b0, 32'hABCD_0000, 32'h400, 8'h20);
        rst_n = 1'b0;
        #1;
        chk("ar_ifid_instr", bus.if_id_instr, 32'd0);
        chk("ar_ifid_pc4", bus.if_id_pc_plus4, 32'd0);
        chk("ar_ifid_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("ar_idex_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("ar_idex_ctrl", {24'd0, bus.id_ex_ctrl}, 32'd0);
        chk("ar_err_clear", {31'd0, bus.stall_err}, 32'd0);
        chk("ar_stall_count", {16'd0, bus.stall_count}, 32'd0);
        chk("ar_pc_write", {31'd0, bus.pc_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'hABCD_0000, 32'h400, 8'h20);
        tick();
        chk("ar_resume_ifid", bus.if_id_instr, 32'hABCD_0000);
        chk("ar_resume_valid", {31'd0, bus.if_id_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
